// File: rtl/sram_req_adapter.sv
// rtl/sram_req_adapter.sv - valid/ready request front end for a fixed-latency SRAM macro
//
// Accepts read/write requests on a valid/ready channel and drives them straight
// onto the SRAM pins in the same cycle. Read data returning Latency cycles later
// is captured into a response FIFO that feeds a valid/ready response channel.
// A credit counter admits a request only when every read still outstanding can
// land in the FIFO, so response backpressure can never drop data.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i                 1 = write, 0 = read
//   req_addr_i               word address
//   req_wdata_i, req_be_i    write data and byte enables
//   rsp_valid_o/rsp_ready_i  read response handshake
//   rsp_rdata_o              read data (FIFO head)
//   sram_req_o, sram_we_o    SRAM request / write enable
//   sram_addr_o              SRAM address
//   sram_wdata_o, sram_be_o  SRAM write data / byte enables
//   sram_rdata_i             SRAM read data, valid Latency cycles after a read
//   busy_o                   reads in flight or responses buffered

module sram_req_adapter #(
  parameter int NumWords  = 32,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int RspDepth  = 2,
  parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 busy_o
);

  localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntWidth = $clog2(RspDepth + 1);

  logic [CntWidth-1:0]  credit_q, credit_d;
  logic [Latency-1:0]   rd_vld_q, rd_vld_d;
  logic [DataWidth-1:0] fifo_mem [RspDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  fifo_count_q, fifo_count_d;

  logic handshake;
  logic rd_accept;
  logic push;
  logic pop;

  // Pointer advance that wraps at RspDepth, so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(RspDepth - 1)) begin
      return '0;
    end
    return p + PtrWidth'(1);
  endfunction

  // Writes are held off without credit too, so a write can never overtake
  // or interleave with a stalled read.
  assign req_ready_o = ~rst_i & (credit_q != '0);
  assign handshake   = req_valid_i & req_ready_o;
  assign rd_accept   = handshake & ~req_we_i;

  assign sram_req_o   = handshake;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_we_i ? req_be_i : '0;

  // The oldest tag marks the cycle in which sram_rdata_i carries read data.
  assign push = rd_vld_q[Latency-1];
  assign pop  = rsp_valid_o & rsp_ready_i;

  assign rsp_valid_o = ~rst_i & (fifo_count_q != '0);
  assign rsp_rdata_o = fifo_mem[rd_ptr_q];
  assign busy_o      = ~rst_i & ((|rd_vld_q) | (fifo_count_q != '0));

  always_comb begin
    rd_vld_d    = '0;
    rd_vld_d[0] = rd_accept;
    for (int i = 1; i < Latency; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({rd_accept, pop})
      2'b10:   credit_d = credit_q - CntWidth'(1);
      2'b01:   credit_d = credit_q + CntWidth'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CntWidth'(1);
      2'b01:   fifo_count_d = fifo_count_q - CntWidth'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q     <= CntWidth'(RspDepth);
      rd_vld_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      credit_q     <= credit_d;
      rd_vld_q     <= rd_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_mem[wr_ptr_q] <= sram_rdata_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (fifo_count_q == CntWidth'(RspDepth))));

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && (fifo_count_q == '0)));

  // Every credit is either free, carried by a read in flight, or a buffered response.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (int'(credit_q) + $countones(rd_vld_q) + int'(fifo_count_q)) == RspDepth);

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb/tb_sram_req_adapter.sv - self-checking bench for sram_req_adapter

module tb_sram_req_adapter;

  localparam int LAT = 1;
  localparam int DEP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sram_req;
  logic        sram_we;
  logic [4:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_req_adapter #(
    .NumWords(32), .DataWidth(32), .ByteWidth(8), .Latency(LAT), .RspDepth(DEP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .busy_o(busy)
  );

  // SRAM macro: byte-masked write at the clock edge, read data LAT cycles later.
  // Outside read slots the data bus carries random junk.
  logic [31:0] sram_mem [32];
  logic [31:0] rd_pipe [LAT];
  assign sram_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
    rd_pipe[0] <= (sram_req && !sram_we) ? sram_mem[sram_addr] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model: a plain memory image plus an ordered list of expected
  // responses, each tagged with the first cycle it may be presented.
  typedef struct {
    logic [31:0] data;
    int          ready_at;
  } rsp_t;

  logic [31:0] ref_mem [32];
  rsp_t        exp_q[$];
  int          credits;
  int          cyc;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic rr);
    logic e_ready, e_hs, e_rv, e_busy;
    rst = r; req_valid = v; req_we = w; req_addr = a;
    req_wdata = d; req_be = b; rsp_ready = rr;
    #1;
    e_ready = !r && (credits != 0);
    e_hs    = v && e_ready;
    e_rv    = 1'b0;
    if (!r && exp_q.size() > 0) e_rv = (exp_q[0].ready_at <= cyc);
    e_busy  = !r && (exp_q.size() > 0);

    chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
    chk("sram_req", {31'b0, sram_req}, {31'b0, e_hs});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    if (!r) chk("credit", 32'(dut.credit_q), 32'(credits));
    if (e_hs) begin
      chk("sram_we", {31'b0, sram_we}, {31'b0, w});
      chk("sram_addr", {27'b0, sram_addr}, {27'b0, a});
      chk("sram_be", {28'b0, sram_be}, w ? {28'b0, b} : 32'h0);
      if (w) chk("sram_wdata", sram_wdata, d);
    end
    if (e_rv) chk("rsp_rdata", rsp_rdata, exp_q[0].data);

    if (r) begin
      exp_q.delete();
      credits = DEP;
    end else begin
      if (e_rv && rr) begin
        void'(exp_q.pop_front());
        credits++;
      end
      if (e_hs) begin
        if (w) begin
          for (int i = 0; i < 4; i++) begin
            if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
          end
        end else begin
          exp_q.push_back('{data: ref_mem[a], ready_at: cyc + LAT + 1});
          credits--;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, rr);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; credits = DEP;
    for (int i = 0; i < 32; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);

    // Write then read back
    step(1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b1);
    idle(3, 1'b1);

    // Byte enables
    step(1'b0, 1'b1, 1'b1, 5'd5, 32'h11223344, 4'hF, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5'd5, 32'hAABBCCDD, 4'h5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 4'h0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: third read stalls until one pop returns a credit
    step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0);
    idle(6, 1'b1);

    // Throughput: fill addresses, then 8 back-to-back reads with ready held high
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 5'(i), 32'h0, 4'h0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-operation, then a fresh read
    step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
           5'($urandom), $urandom, 4'($urandom), ($urandom % 3) != 0);
    end
    idle(6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
